pps_error_formatter: RTL and testbench
======================================

// Module: pps_error_formatter
// PURPOSE
//  Downstream stage of the PPS clock-error counter. Latches each per-second signed error sample and
//  serialises it as a fixed-width ASCII line ("+0000000C\r\n") into the txuart byte interface.
//  Replaces the single raw error byte with a full-resolution, human-readable record per PPS.
// PARAMETERS
//  WIDTH     32  error sample width, two's complement; multiple of 4, range 4..32
//  UPPERCASE 1   1: hex letters 'A'-'F'; 0: 'a'-'f'
//  EOL_CRLF  1   1: line ends "\r\n"; 0: line ends "\n" only
//  (localparam NDIGITS = WIDTH/4; NCHARS = 1 + NDIGITS + (EOL_CRLF ? 2 : 1))
// PORTS
//  clk        in   1      system clock, single domain
//  reset      in   1      synchronous, active-high
//  i_stb      in   1      one-cycle sample-valid pulse from the error counter
//  i_error    in   WIDTH  signed clock error (counted clocks minus nominal)
//  o_tx_stb   out  1      byte-write request to txuart
//  o_tx_data  out  8      ASCII byte; stable while o_tx_stb is high
//  i_tx_busy  in   1      txuart busy; a byte is accepted on a cycle with o_tx_stb && !i_tx_busy
//  o_busy     out  1      high from sample capture until the final EOL byte is accepted
//  o_overrun  out  1      sticky; set when i_stb arrives while o_busy; cleared only by reset
// BEHAVIOUR
//  - Reset (synchronous, every register): state IDLE, o_tx_stb=0, o_tx_data=8'h00, o_busy=0, o_overrun=0,
//    char index=0. Reset mid-line aborts the line on the next edge; a byte already taken by txuart completes there.
//  - FSM: IDLE -> SEND -> GAP -> SEND ... -> IDLE.
//    IDLE: i_stb=1 -> capture sign=i_error[WIDTH-1], mag = sign ? -i_error : i_error (WIDTH-bit unsigned;
//          most-negative value yields mag=2^(WIDTH-1), no overflow); o_busy=1; go SEND. Latency: o_tx_stb
//          high on the cycle after i_stb.
//    SEND: o_tx_stb=1, o_tx_data = char[index]. Hold both unchanged while i_tx_busy=1 (no timeout).
//          On accept: index++, mag shifts left 4 if a digit was sent; go GAP, or IDLE (o_busy=0) after last char.
//    GAP:  exactly one cycle with o_tx_stb=0 (covers txuart's registered busy); go SEND.
//  - Char sequence: index 0 '+'(0x2B) or '-'(0x2D); 1..NDIGITS hex digits of mag, MSB nibble first,
//    leading zeros kept; then 0x0D 0x0A (EOL_CRLF=1) or 0x0A (EOL_CRLF=0).
//  - i_stb while o_busy (including the cycle the last EOL byte is accepted): sample dropped, o_overrun<=1,
//    the line in progress is unaffected. i_stb is sampled only in IDLE.
//  - i_error is sampled only on the capture cycle; later changes do not affect the line.
//  - o_tx_data is don't-care-but-stable (holds last byte) when o_tx_stb=0.
// STRUCTURE
//  - Shared include pps_fmt_defs.vh: ASCII constants (PLUS, MINUS, CR, LF, '0', 'A', 'a') and FSM state
//    encodings (IDLE/SEND/GAP, 2 bits); also used by future line-formatting stages.
//  - Sub-module nibble_to_ascii (combinational: 4-bit nibble + UPPERCASE -> 8-bit ASCII). It is instantiated
//    on the top nibble of the magnitude shift register.
//  - Top level holds the FSM, index counter (width clog2(NCHARS+1)), sign/magnitude registers and output registers.
// TESTING
//  1. i_error=32'd12, i_stb pulse, i_tx_busy=0 -> bytes 2B,30x7,43,0D,0A (11 accepts), one GAP cycle
//     between accepts, o_busy falls the cycle after 0A is accepted.
//  2. i_error=32'hFFFF_FFFB (-5) -> "-00000005\r\n"; i_error=32'h8000_0000 -> "-80000000\r\n".
//  3. UPPERCASE=0, EOL_CRLF=0, i_error=32'h0000_ABCD -> "+0000abcd\n" (10 bytes).
//  4. i_tx_busy held high 100 cycles while the first byte is offered -> o_tx_stb=1 and o_tx_data=2B are
//     stable throughout; the sequence resumes unchanged after release.
//  5. Second i_stb during digit 3, and another on the LF-accept cycle -> both dropped, o_overrun=1 and stays
//     set, the first line completes intact; the next i_stb in IDLE produces a normal line.
//  6. reset pulsed after the 3rd accept -> next cycle o_tx_stb=0, o_busy=0, o_overrun=0; the following
//     i_stb with i_error=0 -> "+00000000\r\n".

Source files
------------

// File: rtl/pps_error_formatter_pkg.sv
// Shared definitions for the PPS line-formatting stages: ASCII constants and
// the 2-bit state encodings used by the serialising FSMs.
package pps_error_formatter_pkg;

  localparam logic [7:0] ASC_PLUS    = 8'h2B;
  localparam logic [7:0] ASC_MINUS   = 8'h2D;
  localparam logic [7:0] ASC_CR      = 8'h0D;
  localparam logic [7:0] ASC_LF      = 8'h0A;
  localparam logic [7:0] ASC_ZERO    = 8'h30;
  localparam logic [7:0] ASC_UPPER_A = 8'h41;
  localparam logic [7:0] ASC_LOWER_A = 8'h61;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/pps_error_formatter_nibble_to_ascii.sv
// Combinational hex-digit encoder: one 4-bit nibble to its ASCII character.
module nibble_to_ascii
  import pps_error_formatter_pkg::*;
#(
  parameter bit UPPERCASE = 1'b1
) (
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  localparam logic [7:0] LETTER_BASE = UPPERCASE ? ASC_UPPER_A : ASC_LOWER_A;

  always_comb begin
    if (i_nibble < 4'd10) begin
      o_ascii = ASC_ZERO + {4'd0, i_nibble};
    end else begin
      o_ascii = LETTER_BASE + {4'd0, i_nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/pps_error_formatter.sv
// Latches one signed PPS error sample per strobe and streams it to txuart as a
// fixed-width ASCII record: sign, zero-padded hex magnitude, end-of-line.
module pps_error_formatter
  import pps_error_formatter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit UPPERCASE = 1'b1,
  parameter bit EOL_CRLF  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_stb,
  input  logic [WIDTH-1:0] i_error,
  output logic             o_tx_stb,
  output logic [7:0]       o_tx_data,
  input  logic             i_tx_busy,
  output logic             o_busy,
  output logic             o_overrun
);

  localparam int NDIGITS = WIDTH / 4;
  localparam int NCHARS  = 1 + NDIGITS + (EOL_CRLF ? 2 : 1);
  localparam int IDXW    = $clog2(NCHARS + 1);

  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NCHARS - 1);
  localparam logic [IDXW-1:0] LAST_DIG  = IDXW'(NDIGITS);
  localparam logic [IDXW-1:0] FIRST_EOL = IDXW'(NDIGITS + 1);

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic             tx_stb_q, tx_stb_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  logic [7:0]       digit_ascii;
  logic [7:0]       cur_char;
  logic             is_digit;

  // The magnitude register shifts left after each digit, so its top nibble is
  // always the next digit to send.
  nibble_to_ascii #(
    .UPPERCASE (UPPERCASE)
  ) u_nibble_to_ascii (
    .i_nibble (mag_q[WIDTH-1 -: 4]),
    .o_ascii  (digit_ascii)
  );

  assign is_digit = (idx_q != '0) && (idx_q <= LAST_DIG);

  always_comb begin
    cur_char = digit_ascii;
    if (idx_q == '0) begin
      cur_char = sign_q ? ASC_MINUS : ASC_PLUS;
    end else if (idx_q > LAST_DIG) begin
      cur_char = (EOL_CRLF && (idx_q == FIRST_EOL)) ? ASC_CR : ASC_LF;
    end
  end

  always_comb begin
    // NOTE: every *_d starts from its *_q so no path through this block can
    // leave a variable unassigned and infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    tx_stb_d  = tx_stb_q;
    tx_data_d = tx_data_q;
    busy_d    = busy_q;
    overrun_d = overrun_q;

    if (i_stb && busy_q) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_stb) begin
          sign_d    = i_error[WIDTH-1];
          // Two's-complement negate; the most-negative input maps onto itself,
          // which read as unsigned is exactly its magnitude.
          mag_d     = i_error[WIDTH-1] ? -i_error : i_error;
          idx_d     = '0;
          busy_d    = 1'b1;
          tx_stb_d  = 1'b1;
          tx_data_d = i_error[WIDTH-1] ? ASC_MINUS : ASC_PLUS;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!i_tx_busy) begin
          tx_stb_d = 1'b0;
          if (is_digit) begin
            mag_d = mag_q << 4;
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        tx_stb_d  = 1'b1;
        tx_data_d = cur_char;
        state_d   = ST_SEND;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      tx_stb_q  <= 1'b0;
      tx_data_q <= 8'h00;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      tx_stb_q  <= tx_stb_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_tx_stb  = tx_stb_q;
  assign o_tx_data = tx_data_q;
  assign o_busy    = busy_q;
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_pps_error_formatter.sv
// Directed bench for pps_error_formatter: default build plus a lowercase / LF-only build.
module tb_pps_error_formatter;

  logic        clk = 1'b0;
  logic        reset;
  logic        stb_a, stb_b;
  logic [31:0] err;
  logic        tx_busy;

  logic        tx_stb_a, tx_stb_b;
  logic [7:0]  tx_data_a, tx_data_b;
  logic        busy_a, busy_b;
  logic        overrun_a, overrun_b;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] got     [0:15];
  int         got_cyc [0:15];
  int         got_n;

  always #5 clk = ~clk;

  pps_error_formatter dut_a (
    .clk       (clk),
    .reset     (reset),
    .i_stb     (stb_a),
    .i_error   (err),
    .o_tx_stb  (tx_stb_a),
    .o_tx_data (tx_data_a),
    .i_tx_busy (tx_busy),
    .o_busy    (busy_a),
    .o_overrun (overrun_a)
  );

  pps_error_formatter #(
    .WIDTH     (32),
    .UPPERCASE (1'b0),
    .EOL_CRLF  (1'b0)
  ) dut_b (
    .clk       (clk),
    .reset     (reset),
    .i_stb     (stb_b),
    .i_error   (err),
    .o_tx_stb  (tx_stb_b),
    .o_tx_data (tx_data_b),
    .i_tx_busy (tx_busy),
    .o_busy    (busy_b),
    .o_overrun (overrun_b)
  );

  // Called on a falling edge; returns on the next falling edge, after the capture edge.
  task automatic pulse(input int which, input logic [31:0] value);
    err = value;
    if (which == 0) stb_a = 1'b1; else stb_b = 1'b1;
    @(negedge clk);
    stb_a = 1'b0;
    stb_b = 1'b0;
  endtask

  // Records accepted bytes until nexp are seen or max_cyc elapses. A strobe is
  // raised on the accept cycle of byte index inj0 / inj1 (-1 disables).
  task automatic collect(input int which, input int nexp, input int max_cyc,
                         input int inj0, input int inj1);
    int cyc = 0;
    got_n = 0;
    while (got_n < nexp && cyc < max_cyc) begin
      if (which == 0 && tx_stb_a && !tx_busy) begin
        got[got_n] = tx_data_a;
        got_cyc[got_n] = cyc;
        if (got_n == inj0 || got_n == inj1) begin
          stb_a = 1'b1;
          err   = 32'hDEAD_BEEF;
        end
        got_n++;
      end else if (which == 1 && tx_stb_b && !tx_busy) begin
        got[got_n] = tx_data_b;
        got_cyc[got_n] = cyc;
        got_n++;
      end
      @(negedge clk);
      stb_a = 1'b0;
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({tx_stb_a, tx_data_a, busy_a, overrun_a} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: stb=%b data=%h busy=%b ovr=%b, want 0 00 0 0",
               tx_stb_a, tx_data_a, busy_a, overrun_a);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_line;
    string exp = "+0000000C\r\n";
    pulse(0, 32'd12);
    n_cmp++;
    if (tx_stb_a !== 1'b1 || busy_a !== 1'b1) begin
      n_err++;
      $display("FAIL basic_latency: stb=%b busy=%b, want 1 1", tx_stb_a, busy_a);
    end
    collect(0, exp.len(), 200, -1, -1);
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL basic_busy_fall: busy=%b, want 0", busy_a);
    end
    n_cmp++;
    if (got_n != exp.len()) begin
      n_err++;
      $display("FAIL basic_count: got %0d bytes, want %0d", got_n, exp.len());
    end
    for (int i = 0; i < got_n; i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_err++;
        $display("FAIL basic_byte%0d: got %h, want %h", i, got[i], exp[i]);
      end
    end
    for (int i = 1; i < got_n; i++) begin
      n_cmp++;
      if (got_cyc[i] - got_cyc[i-1] != 2) begin
        n_err++;
        $display("FAIL basic_gap%0d: spacing %0d, want 2", i, got_cyc[i] - got_cyc[i-1]);
      end
    end
  endtask

  task automatic test_negative;
    string exp [2] = '{"-00000005\r\n", "-80000000\r\n"};
    logic [31:0] val [2] = '{32'hFFFF_FFFB, 32'h8000_0000};
    for (int t = 0; t < 2; t++) begin
      pulse(0, val[t]);
      collect(0, exp[t].len(), 200, -1, -1);
      n_cmp++;
      if (got_n != exp[t].len()) begin
        n_err++;
        $display("FAIL neg%0d_count: got %0d bytes, want %0d", t, got_n, exp[t].len());
      end
      for (int i = 0; i < got_n; i++) begin
        n_cmp++;
        if (got[i] !== exp[t][i]) begin
          n_err++;
          $display("FAIL neg%0d_byte%0d: got %h, want %h", t, i, got[i], exp[t][i]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lower_lf;
    string exp = "+0000abcd\n";
    pulse(1, 32'h0000_ABCD);
    collect(1, 12, 200, -1, -1);
    n_cmp++;
    if (got_n != exp.len()) begin
      n_err++;
      $display("FAIL lower_count: got %0d bytes, want %0d", got_n, exp.len());
    end
    for (int i = 0; i < got_n && i < exp.len(); i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_err++;
        $display("FAIL lower_byte%0d: got %h, want %h", i, got[i], exp[i]);
      end
    end
    n_cmp++;
    if (busy_b !== 1'b0) begin
      n_err++;
      $display("FAIL lower_busy: busy=%b, want 0", busy_b);
    end
  endtask

  task automatic test_backpressure;
    string exp = "+000000FF\r\n";
    bit stable = 1'b1;
    tx_busy = 1'b1;
    pulse(0, 32'h0000_00FF);
    for (int c = 0; c < 100; c++) begin
      if (stable && (tx_stb_a !== 1'b1 || tx_data_a !== 8'h2B)) begin
        stable = 1'b0;
        $display("FAIL hold_stable: cycle %0d stb=%b data=%h, want 1 2b", c, tx_stb_a, tx_data_a);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!stable) n_err++;
    tx_busy = 1'b0;
    collect(0, exp.len(), 200, -1, -1);
    n_cmp++;
    if (got_n != exp.len()) begin
      n_err++;
      $display("FAIL hold_count: got %0d bytes, want %0d", got_n, exp.len());
    end
    for (int i = 0; i < got_n; i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_err++;
        $display("FAIL hold_byte%0d: got %h, want %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_overrun;
    string exp  = "+12345678\r\n";
    string exp2 = "-00000001\r\n";
    n_cmp++;
    if (overrun_a !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_initial: ovr=%b, want 0", overrun_a);
    end
    pulse(0, 32'h1234_5678);
    collect(0, exp.len(), 200, 3, 10);
    n_cmp++;
    if (overrun_a !== 1'b1 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_set: ovr=%b busy=%b, want 1 0", overrun_a, busy_a);
    end
    n_cmp++;
    if (got_n != exp.len()) begin
      n_err++;
      $display("FAIL ovr_count: got %0d bytes, want %0d", got_n, exp.len());
    end
    for (int i = 0; i < got_n; i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_err++;
        $display("FAIL ovr_byte%0d: got %h, want %h", i, got[i], exp[i]);
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (tx_stb_a !== 1'b0 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_dropped: stb=%b busy=%b, want 0 0", tx_stb_a, busy_a);
    end
    pulse(0, 32'hFFFF_FFFF);
    collect(0, exp2.len(), 200, -1, -1);
    n_cmp++;
    if (got_n != exp2.len() || overrun_a !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_next_line: got %0d bytes ovr=%b, want %0d 1", got_n, overrun_a, exp2.len());
    end
    for (int i = 0; i < got_n; i++) begin
      n_cmp++;
      if (got[i] !== exp2[i]) begin
        n_err++;
        $display("FAIL ovr_next_byte%0d: got %h, want %h", i, got[i], exp2[i]);
      end
    end
  endtask

  task automatic test_mid_reset;
    string exp = "+00000000\r\n";
    pulse(0, 32'h0000_0077);
    collect(0, 3, 50, -1, -1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if ({tx_stb_a, tx_data_a, busy_a, overrun_a} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL midreset_state: stb=%b data=%h busy=%b ovr=%b, want 0 00 0 0",
               tx_stb_a, tx_data_a, busy_a, overrun_a);
    end
    repeat (2) @(negedge clk);
    pulse(0, 32'h0000_0000);
    collect(0, exp.len(), 200, -1, -1);
    n_cmp++;
    if (got_n != exp.len()) begin
      n_err++;
      $display("FAIL midreset_count: got %0d bytes, want %0d", got_n, exp.len());
    end
    for (int i = 0; i < got_n; i++) begin
      n_cmp++;
      if (got[i] !== exp[i]) begin
        n_err++;
        $display("FAIL midreset_byte%0d: got %h, want %h", i, got[i], exp[i]);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    stb_a   = 1'b0;
    stb_b   = 1'b0;
    err     = '0;
    tx_busy = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_line();
    @(negedge clk);
    test_negative();
    test_lower_lf();
    @(negedge clk);
    test_backpressure();
    @(negedge clk);
    test_overrun();
    @(negedge clk);
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
